pipe_stage_reg: RTL

- Parametrised, elastic successor to the fixed ID/EX-style latch.
- Registers one control bundle and one data bundle between two pipeline stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, a flush that kills in-flight entries, and guaranteed zeroed control on bubbles.
- Instantiated at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with different widths.

---
 rtl/pipe_pkg.sv | 47 ++++
 rtl/pipe_skid_buf.sv | 70 +++++++
 rtl/pipe_stage_reg.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline stage register family.
//
// Contents:
//   pipe_state_t / ST_*  : stage occupancy encoding {main_valid, skid_valid}
//   CTRL_*               : bit positions inside the control bundle
//   *_DATA_W             : default data-bundle widths per stage boundary
//   ctrl_is_write        : true when a control word can modify architectural
//                          state (RegWrite or MemWrite set)
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Occupancy encoding: bit 1 = main register valid, bit 0 = skid valid.
  // 2'b01 is unreachable; the stage treats it as a fault and recovers to EMPTY.
  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t ST_EMPTY = 2'b00;
  localparam pipe_state_t ST_FULL  = 2'b10;
  localparam pipe_state_t ST_SKID  = 2'b11;

  // Control bundle bit positions.
  localparam int CTRL_REGDST    = 0;
  localparam int CTRL_BRANCH    = 1;
  localparam int CTRL_MEMREAD   = 2;
  localparam int CTRL_MEMTOREG  = 3;
  localparam int CTRL_MEMWRITE  = 4;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGWRITE  = 6;
  localparam int CTRL_SHIFT     = 7;
  localparam int CTRL_FIN       = 8;
  localparam int CTRL_ALUOP_LSB = 9;
  localparam int CTRL_ALUOP_MSB = 10;
  localparam int CTRL_W_DEFAULT = 11;

  // Default data-bundle widths for each stage boundary.
  localparam int IFID_DATA_W  = 64;   // pc + instruction
  localparam int IDEX_DATA_W  = 186;  // operands, sign-ext, instruction fields
  localparam int EXMEM_DATA_W = 107;  // alu result, store data, dest, branch target
  localparam int MEMWB_DATA_W = 71;   // load data, alu result, dest

  // A control word that would write register file or memory.
  function automatic logic ctrl_is_write(input logic [CTRL_W_DEFAULT-1:0] ctrl);
    return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMWRITE];
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Single-entry skid register with its valid bit. Catches the entry accepted
// in the cycle the downstream stalls, so the upstream handshake can be fully
// registered.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   load       in   capture load_ctrl/load_data and mark valid
//   clear      in   entry moved to the main register; invalidate
//   flush      in   kill the held entry; highest priority after reset
//   load_ctrl  in   [CTRL_W] control bundle to capture
//   load_data  in   [DATA_W] data bundle to capture
//   valid      out  entry held
//   ctrl       out  [CTRL_W] held control bundle (zero when not valid)
//   data       out  [DATA_W] held data bundle
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int DATA_W = IDEX_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              flush,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;

  // Skid entry storage: ctrl is zeroed whenever the entry stops being valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
      data_r  <= data_r;
    end else if (clear) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
      data_r  <= data_r;
    end else if (load) begin
      valid_r <= 1'b1;
      ctrl_r  <= load_ctrl;
      data_r  <= load_data;
    end else begin
      valid_r <= valid_r;
      ctrl_r  <= ctrl_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign ctrl  = ctrl_r;
  assign data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic pipeline stage register: one control bundle plus one data bundle,
// valid/ready on both sides, a skid entry so in_ready is a pure register,
// flush that kills held entries, and control forced to zero on bubbles so a
// bubble can never carry RegWrite/MemWrite.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   in_valid    in   upstream presents an entry
//   in_ready    out  stage accepts an entry this cycle (registered, !skid_valid)
//   in_ctrl     in   [CTRL_W] control bundle from upstream
//   in_data     in   [DATA_W] data bundle from upstream
//   flush       in   kill all held entries; a same-cycle drain still completes
//   out_valid   out  entry presented downstream
//   out_ready   in   downstream accepts the entry
//   out_ctrl    out  [CTRL_W] control bundle; zero whenever out_valid=0
//   out_data    out  [DATA_W] data bundle; holds last value on bubbles
//   bubble_cnt  out  [CNT_W] saturating count of cycles with !out_valid && out_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Main register (drives the outputs directly).
  logic              main_valid_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic              in_ready_r;
  logic [CNT_W-1:0]  bubble_cnt_r;

  // Skid entry.
  logic              skid_valid_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;

  // Handshake and next-state decode.
  logic              accept_s;
  logic              drain_s;
  pipe_state_t       state_s;
  pipe_state_t       nxt_state_s;
  logic              main_load_in_s;
  logic              main_load_skid_s;
  logic              skid_load_s;
  logic              skid_clear_s;

  assign accept_s = in_valid & in_ready_r;
  assign drain_s  = main_valid_r & out_ready;
  assign state_s  = {main_valid_r, skid_valid_s};

  // Occupancy state machine; flush overrides every transition. A drain in a
  // flush cycle needs no action here: downstream already took the entry.
  always_comb begin
    nxt_state_s      = state_s;
    main_load_in_s   = 1'b0;
    main_load_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clear_s     = 1'b0;
    if (flush) begin
      nxt_state_s = ST_EMPTY;
    end else begin
      case (state_s)
        ST_EMPTY: begin
          if (accept_s) begin
            nxt_state_s    = ST_FULL;
            main_load_in_s = 1'b1;
          end else begin
            nxt_state_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && drain_s) begin
            nxt_state_s    = ST_FULL;
            main_load_in_s = 1'b1;
          end else if (accept_s) begin
            nxt_state_s = ST_SKID;
            skid_load_s = 1'b1;
          end else if (drain_s) begin
            nxt_state_s = ST_EMPTY;
          end else begin
            nxt_state_s = ST_FULL;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so accept_s cannot be set.
          if (drain_s) begin
            nxt_state_s      = ST_FULL;
            main_load_skid_s = 1'b1;
            skid_clear_s     = 1'b1;
          end else begin
            nxt_state_s = ST_SKID;
          end
        end
        default: begin
          // Unreachable {0,1}: drop the orphaned skid entry and restart empty.
          nxt_state_s  = ST_EMPTY;
          skid_clear_s = 1'b1;
        end
      endcase
    end
  end

  // Main register: loads from upstream or the skid entry; ctrl is cleared in
  // the register itself whenever the stage goes empty, data keeps its value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_ctrl_r  <= {CTRL_W{1'b0}};
      main_data_r  <= {DATA_W{1'b0}};
    end else begin
      main_valid_r <= nxt_state_s[1];
      if (main_load_in_s) begin
        main_ctrl_r <= in_ctrl;
        main_data_r <= in_data;
      end else if (main_load_skid_s) begin
        main_ctrl_r <= skid_ctrl_s;
        main_data_r <= skid_data_s;
      end else if (!nxt_state_s[1]) begin
        main_ctrl_r <= {CTRL_W{1'b0}};
        main_data_r <= main_data_r;
      end else begin
        main_ctrl_r <= main_ctrl_r;
        main_data_r <= main_data_r;
      end
    end
  end

  // in_ready is the registered complement of the next skid occupancy, so
  // out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_r <= 1'b1;
    end else begin
      in_ready_r <= ~nxt_state_s[0];
    end
  end

  // Saturating bubble counter; only reset clears it, flush does not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (!main_valid_r && out_ready && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load_s),
    .clear     (skid_clear_s),
    .flush     (flush),
    .load_ctrl (in_ctrl),
    .load_data (in_data),
    .valid     (skid_valid_s),
    .ctrl      (skid_ctrl_s),
    .data      (skid_data_s)
  );

  assign in_ready   = in_ready_r;
  assign out_valid  = main_valid_r;
  assign out_ctrl   = main_ctrl_r;
  assign out_data   = main_data_r;
  assign bubble_cnt = bubble_cnt_r;

endmodule
